dccm_axi_slave: RTL

//  AXI responder (slave) fronting the DCCM word SRAM; the memory-side end of the mau AXI master link.

---
 rtl/dccm_axi_slave.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/dccm_axi_slave.sv
// AXI responder for the DCCM word SRAM: single/INCR/FIXED bursts, reads and writes share one memory port.
// Define DCCM_WSTRB_EN to add s_axi_wstrb byte-lane write enables; otherwise every beat writes the full word.
`timescale 1ns/1ps
module dccm_axi_slave #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          ID_W      = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     s_axi_araddr,
  input  logic [1:0]      s_axi_arburst,
  input  logic [ID_W-1:0] s_axi_arid,
  input  logic [7:0]      s_axi_arlen,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  output logic [31:0]     s_axi_rdata,
  output logic [ID_W-1:0] s_axi_rid,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rlast,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready,
  input  logic [31:0]     s_axi_awaddr,
  input  logic [1:0]      s_axi_awburst,
  input  logic [ID_W-1:0] s_axi_awid,
  input  logic [7:0]      s_axi_awlen,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [31:0]     s_axi_wdata,
`ifdef DCCM_WSTRB_EN
  input  logic [3:0]      s_axi_wstrb,
`endif
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [ID_W-1:0] s_axi_bid,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [30:0] BASE_W = {1'b0, BASE_ADDR[31:2]};
  localparam logic [30:0] TOP_W  = BASE_W + 31'(DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR_DATA, WR_RESP} state_t;

  state_t      state, state_nxt;
  logic        last_grant_wr;
  logic [31:0] mem [DEPTH];

  // Beat addresses are kept as 31-bit word numbers so INCR bursts past 4 GiB stay out of range.
  logic [30:0] rd_word, wr_word, rd_src_word;
  logic [1:0]  rd_burst, wr_burst, rd_src_burst;
  logic [7:0]  rd_cnt, wr_cnt;
  logic        wr_err;
  logic        rd_src_ok, wr_ok;
  logic [31:0] rd_src_data;
  logic        grant_rd, grant_wr;
  logic        ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic [3:0]  wstrb_eff;
  logic        unused_addr_lsbs;

  function automatic logic beat_ok(input logic [30:0] w, input logic [1:0] burst);
    return !burst[1] && (w >= BASE_W) && (w < TOP_W);
  endfunction

  function automatic logic [AW-1:0] widx(input logic [30:0] w);
    return AW'(w - BASE_W);
  endfunction

  function automatic logic [30:0] next_word(input logic [30:0] w, input logic [1:0] burst);
    return (burst == 2'b01) ? w + 31'd1 : w;
  endfunction

`ifdef DCCM_WSTRB_EN
  assign wstrb_eff = s_axi_wstrb;
`else
  assign wstrb_eff = 4'hF;
`endif
  assign unused_addr_lsbs = ^{s_axi_araddr[1:0], s_axi_awaddr[1:0]};

  // Both requesting: alternate, starting with read since last_grant resets to write.
  assign grant_rd = s_axi_arvalid && (!s_axi_awvalid || last_grant_wr);
  assign grant_wr = s_axi_awvalid && (!s_axi_arvalid || !last_grant_wr);

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign b_hs  = s_axi_bvalid && s_axi_bready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ar_hs)      state_nxt = RD;
        else if (aw_hs) state_nxt = WR_DATA;
      end
      RD:      if (r_hs && s_axi_rlast)        state_nxt = IDLE;
      WR_DATA: if (w_hs && (wr_cnt == 8'd0))   state_nxt = WR_RESP;
      WR_RESP: if (b_hs)                       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    case (state)
      IDLE: begin
        s_axi_arready = grant_rd;
        s_axi_awready = grant_wr;
      end
      WR_DATA: s_axi_wready = 1'b1;
      default: ;
    endcase
  end

  // Address of the beat about to be loaded into the R registers: first beat from AR, later ones stepped.
  always_comb begin
    if (state == IDLE) begin
      rd_src_word  = {1'b0, s_axi_araddr[31:2]};
      rd_src_burst = s_axi_arburst;
    end else begin
      rd_src_word  = next_word(rd_word, rd_burst);
      rd_src_burst = rd_burst;
    end
    rd_src_ok   = beat_ok(rd_src_word, rd_src_burst);
    rd_src_data = rd_src_ok ? mem[widx(rd_src_word)] : 32'h0;
  end

  assign wr_ok = beat_ok(wr_word, wr_burst);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_wr <= 1'b1;
      rd_word       <= '0;
      rd_burst      <= '0;
      rd_cnt        <= '0;
      wr_word       <= '0;
      wr_burst      <= '0;
      wr_cnt        <= '0;
      wr_err        <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= '0;
      s_axi_rlast   <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
      s_axi_bvalid  <= 1'b0;
    end else begin
      if (ar_hs) last_grant_wr <= 1'b0;
      if (aw_hs) last_grant_wr <= 1'b1;

      if (ar_hs || (r_hs && !s_axi_rlast)) begin
        rd_word      <= rd_src_word;
        rd_burst     <= rd_src_burst;
        rd_cnt       <= ar_hs ? s_axi_arlen : rd_cnt - 8'd1;
        s_axi_rlast  <= ar_hs ? (s_axi_arlen == 8'd0) : (rd_cnt == 8'd1);
        s_axi_rdata  <= rd_src_data;
        s_axi_rresp  <= rd_src_ok ? RESP_OKAY : RESP_SLVERR;
        s_axi_rvalid <= 1'b1;
      end else if (r_hs) begin
        s_axi_rvalid <= 1'b0;
        s_axi_rlast  <= 1'b0;
      end
      if (ar_hs) s_axi_rid <= s_axi_arid;

      if (aw_hs) begin
        wr_word   <= {1'b0, s_axi_awaddr[31:2]};
        wr_burst  <= s_axi_awburst;
        wr_cnt    <= s_axi_awlen;
        wr_err    <= 1'b0;
        s_axi_bid <= s_axi_awid;
      end
      if (w_hs) begin
        wr_err <= wr_err || !wr_ok;
        if (wr_cnt == 8'd0) begin
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= (wr_err || !wr_ok) ? RESP_SLVERR : RESP_OKAY;
        end else begin
          wr_cnt  <= wr_cnt - 8'd1;
          wr_word <= next_word(wr_word, wr_burst);
        end
      end
      if (b_hs) s_axi_bvalid <= 1'b0;
    end
  end

  // Storage is deliberately not reset; an aborted burst keeps the beats it already wrote.
  always_ff @(posedge clk) begin
    if (w_hs && wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_eff[i]) mem[widx(wr_word)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

endmodule
